// File: rtl/commit_stream_checker.sv
// Commit-stream scoreboard: buffers an expected retire trace and checks up to
// N_LANES CPU commits per cycle against it, with statistics and error flags.
module commit_stream_checker #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int N_LANES          = 2,
  parameter int DEPTH            = 16,
  parameter int COUNT_WIDTH      = 32,
  parameter int TIMEOUT          = 1024,
  parameter int STOP_ON_MISMATCH = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         end_pc_i,
  input  logic                          exp_valid_i,
  output logic                          exp_ready_o,
  input  logic [ADDR_WIDTH-1:0]         exp_pc_i,
  input  logic [31:0]                   exp_instr_i,
  input  logic                          exp_rd_we_i,
  input  logic [4:0]                    exp_rd_i,
  input  logic [DATA_WIDTH-1:0]         exp_rd_data_i,
  input  logic [N_LANES-1:0]            cmt_valid_i,
  input  logic [N_LANES*ADDR_WIDTH-1:0] cmt_pc_i,
  input  logic [N_LANES*32-1:0]         cmt_instr_i,
  input  logic [N_LANES-1:0]            cmt_rd_we_i,
  input  logic [N_LANES*5-1:0]          cmt_rd_i,
  input  logic [N_LANES*DATA_WIDTH-1:0] cmt_rd_data_i,
  output logic                          done_o,
  output logic                          pass_o,
  output logic                          err_mismatch_o,
  output logic                          err_underflow_o,
  output logic                          err_timeout_o,
  output logic                          err_protocol_o,
  output logic [COUNT_WIDTH-1:0]        instr_count_o,
  output logic [COUNT_WIDTH-1:0]        cycle_count_o,
  output logic [COUNT_WIDTH-1:0]        mismatch_count_o,
  output logic [ADDR_WIDTH-1:0]         first_fail_pc_o,
  output logic [COUNT_WIDTH-1:0]        first_fail_idx_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int LW    = $clog2(N_LANES + 1);
  localparam int IW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW:0] TMO_V = (IW+1)'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;

  state_t                 r_state;
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]       r_occ;
  logic [IW-1:0]          r_idle;
  logic [COUNT_WIDTH-1:0] r_instr_cnt, r_cycle_cnt, r_mis_cnt, r_ff_idx;
  logic [ADDR_WIDTH-1:0]  r_ff_pc;
  logic                   r_err_mis, r_err_under, r_err_tmo, r_err_proto;
  logic                   r_done, r_pass;

  logic [ADDR_WIDTH-1:0]  r_mem_pc    [DEPTH];
  logic [31:0]            r_mem_instr [DEPTH];
  logic                   r_mem_we    [DEPTH];
  logic [4:0]             r_mem_rd    [DEPTH];
  logic [DATA_WIDTH-1:0]  r_mem_data  [DEPTH];

  logic w_run, w_restart, w_push;
  assign w_run       = (r_state == S_RUN);
  assign w_restart   = start_i && (r_state != S_RUN);
  assign exp_ready_o = (r_occ < OCC_W'(DEPTH));
  assign w_push      = exp_valid_i && exp_ready_o && !w_restart;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= exp_pc_i;
      r_mem_instr[r_wr_ptr] <= exp_instr_i;
      r_mem_we[r_wr_ptr]    <= exp_rd_we_i;
      r_mem_rd[r_wr_ptr]    <= exp_rd_i;
      r_mem_data[r_wr_ptr]  <= exp_rd_data_i;
    end
  end

  // Lane gi is compared against the entry gi places behind the FIFO head.
  logic [N_LANES-1:0] w_lane_ok, w_lane_end, w_lane_mis;
  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    logic [PTR_W-1:0]      w_idx;
    logic [ADDR_WIDTH-1:0] w_pc;
    logic [31:0]           w_instr;
    logic [4:0]            w_rd;
    logic [DATA_WIDTH-1:0] w_data;
    assign w_idx   = r_rd_ptr + PTR_W'(gi);
    assign w_pc    = cmt_pc_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_instr = cmt_instr_i[gi*32 +: 32];
    assign w_rd    = cmt_rd_i[gi*5 +: 5];
    assign w_data  = cmt_rd_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_lane_ok[gi]  = cmt_valid_i[gi] && (OCC_W'(gi) < r_occ);
    assign w_lane_end[gi] = (w_pc == end_pc_i);
    assign w_lane_mis[gi] = (w_pc != r_mem_pc[w_idx]) || (w_instr != r_mem_instr[w_idx]) ||
                            (cmt_rd_we_i[gi] != r_mem_we[w_idx]) ||
                            (r_mem_we[w_idx] && ((w_rd != r_mem_rd[w_idx]) ||
                             ((r_mem_rd[w_idx] != 5'd0) && (w_data != r_mem_data[w_idx]))));
  end

  logic [LW-1:0]      w_k, w_n_cmp, w_mis_n, w_ff_lane;
  logic [N_LANES-1:0] w_vplus;
  logic               w_contig, w_end_hit, w_mis_any;

  assign w_vplus  = cmt_valid_i + N_LANES'(1);
  assign w_contig = ((w_vplus & cmt_valid_i) == '0);

  always_comb begin
    w_k = '0;
    for (int i = 0; i < N_LANES; i++) w_k = w_k + LW'(cmt_valid_i[i]);
  end

  // Compare in lane order; the first lane carrying the end PC closes the window.
  always_comb begin
    w_n_cmp   = '0;
    w_end_hit = 1'b0;
    w_mis_n   = '0;
    w_mis_any = 1'b0;
    w_ff_lane = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (w_run && w_contig && !w_end_hit && w_lane_ok[i]) begin
        w_n_cmp = LW'(i + 1);
        if (w_lane_mis[i]) begin
          if (!w_mis_any) w_ff_lane = LW'(i);
          w_mis_any = 1'b1;
          w_mis_n   = w_mis_n + LW'(1);
        end
        if (w_lane_end[i]) w_end_hit = 1'b1;
      end
    end
  end

  logic                   w_proto, w_under, w_tmo, w_fail_now;
  logic [IW:0]            w_idle_inc;
  logic [COUNT_WIDTH:0]   w_instr_sum, w_mis_sum;
  logic [COUNT_WIDTH-1:0] w_instr_next, w_mis_next, w_cycle_next;
  logic                   w_em_next, w_eu_next, w_et_next, w_ep_next;
  state_t                 w_state_next;

  assign w_proto    = w_run && !w_contig;
  assign w_under    = w_run && w_contig && !w_end_hit && (OCC_W'(w_k) > r_occ);
  assign w_idle_inc = {1'b0, r_idle} + (IW+1)'(1);
  assign w_tmo      = (TIMEOUT != 0) && w_run && (w_k == '0) && (w_idle_inc == TMO_V);
  assign w_fail_now = w_proto || w_under || w_tmo || ((STOP_ON_MISMATCH != 0) && w_mis_any);

  assign w_instr_sum  = {1'b0, r_instr_cnt} + (COUNT_WIDTH+1)'(w_n_cmp);
  assign w_mis_sum    = {1'b0, r_mis_cnt} + (COUNT_WIDTH+1)'(w_mis_n);
  assign w_instr_next = w_instr_sum[COUNT_WIDTH] ? '1 : w_instr_sum[COUNT_WIDTH-1:0];
  assign w_mis_next   = w_mis_sum[COUNT_WIDTH] ? '1 : w_mis_sum[COUNT_WIDTH-1:0];
  assign w_cycle_next = (r_cycle_cnt == '1) ? r_cycle_cnt : r_cycle_cnt + COUNT_WIDTH'(1);

  assign w_em_next = r_err_mis   || w_mis_any;
  assign w_eu_next = r_err_under || w_under;
  assign w_et_next = r_err_tmo   || w_tmo;
  assign w_ep_next = r_err_proto || w_proto;

  always_comb begin
    w_state_next = r_state;
    if (w_run) begin
      if (w_fail_now)     w_state_next = S_FAIL;
      else if (w_end_hit) w_state_next = S_DONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_occ <= '0; r_idle <= '0;
      r_instr_cnt <= '0; r_cycle_cnt <= '0; r_mis_cnt <= '0;
      r_ff_pc <= '0; r_ff_idx <= '0;
      r_err_mis <= 1'b0; r_err_under <= 1'b0; r_err_tmo <= 1'b0; r_err_proto <= 1'b0;
      r_done <= 1'b0; r_pass <= 1'b0;
    end else if (w_restart) begin
      r_state <= S_RUN;
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_occ <= '0; r_idle <= '0;
      r_instr_cnt <= '0; r_cycle_cnt <= '0; r_mis_cnt <= '0;
      r_ff_pc <= '0; r_ff_idx <= '0;
      r_err_mis <= 1'b0; r_err_under <= 1'b0; r_err_tmo <= 1'b0; r_err_proto <= 1'b0;
      r_done <= 1'b0; r_pass <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == S_DONE) || (w_state_next == S_FAIL);
      r_pass  <= (w_state_next == S_DONE) && !(w_em_next || w_eu_next || w_et_next || w_ep_next);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_cmp);
      r_occ    <= r_occ + OCC_W'(w_push) - OCC_W'(w_n_cmp);
      if (w_run) begin
        r_idle      <= (w_k != '0) ? '0 : w_idle_inc[IW-1:0];
        r_cycle_cnt <= w_cycle_next;
        r_instr_cnt <= w_instr_next;
        r_mis_cnt   <= w_mis_next;
        r_err_mis   <= w_em_next;
        r_err_under <= w_eu_next;
        r_err_tmo   <= w_et_next;
        r_err_proto <= w_ep_next;
        if (w_mis_any && !r_err_mis) begin
          r_ff_pc  <= cmt_pc_i[w_ff_lane*ADDR_WIDTH +: ADDR_WIDTH];
          r_ff_idx <= r_instr_cnt + COUNT_WIDTH'(w_ff_lane);
        end
      end
    end
  end

  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign err_mismatch_o   = r_err_mis;
  assign err_underflow_o  = r_err_under;
  assign err_timeout_o    = r_err_tmo;
  assign err_protocol_o   = r_err_proto;
  assign instr_count_o    = r_instr_cnt;
  assign cycle_count_o    = r_cycle_cnt;
  assign mismatch_count_o = r_mis_cnt;
  assign first_fail_pc_o  = r_ff_pc;
  assign first_fail_idx_o = r_ff_idx;
endmodule

// File: tb/tb_commit_stream_checker.sv
// Directed bench for commit_stream_checker: expected status snapshots are queued
// as stimulus is driven and compared after each transaction.
module tb_commit_stream_checker;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NL = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i, start_i, exp_valid_i, exp_ready_o, exp_rd_we_i;
  logic [AW-1:0]    end_pc_i, exp_pc_i;
  logic [31:0]      exp_instr_i;
  logic [4:0]       exp_rd_i;
  logic [DW-1:0]    exp_rd_data_i;
  logic [NL-1:0]    cmt_valid_i, cmt_rd_we_i;
  logic [NL*AW-1:0] cmt_pc_i;
  logic [NL*32-1:0] cmt_instr_i;
  logic [NL*5-1:0]  cmt_rd_i;
  logic [NL*DW-1:0] cmt_rd_data_i;
  logic             done_o, pass_o, err_mismatch_o, err_underflow_o, err_timeout_o, err_protocol_o;
  logic [CW-1:0]    instr_count_o, cycle_count_o, mismatch_count_o, first_fail_idx_o;
  logic [AW-1:0]    first_fail_pc_o;

  commit_stream_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_LANES(NL), .DEPTH(16),
    .COUNT_WIDTH(CW), .TIMEOUT(8), .STOP_ON_MISMATCH(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .end_pc_i(end_pc_i),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o), .exp_pc_i(exp_pc_i),
    .exp_instr_i(exp_instr_i), .exp_rd_we_i(exp_rd_we_i), .exp_rd_i(exp_rd_i),
    .exp_rd_data_i(exp_rd_data_i), .cmt_valid_i(cmt_valid_i), .cmt_pc_i(cmt_pc_i),
    .cmt_instr_i(cmt_instr_i), .cmt_rd_we_i(cmt_rd_we_i), .cmt_rd_i(cmt_rd_i),
    .cmt_rd_data_i(cmt_rd_data_i), .done_o(done_o), .pass_o(pass_o),
    .err_mismatch_o(err_mismatch_o), .err_underflow_o(err_underflow_o),
    .err_timeout_o(err_timeout_o), .err_protocol_o(err_protocol_o),
    .instr_count_o(instr_count_o), .cycle_count_o(cycle_count_o),
    .mismatch_count_o(mismatch_count_o), .first_fail_pc_o(first_fail_pc_o),
    .first_fail_idx_o(first_fail_idx_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  // Field value -1 means "not checked"; flags = {mismatch,underflow,timeout,protocol}.
  typedef struct {
    string tag;
    int ready, done, pass, flags, instr, cyc, mis, ffpc, ffidx;
  } status_t;

  status_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic entry_t mk(input int i);
    entry_t e;
    e.pc    = 32'(4 * i);
    e.instr = 32'h0010_0093 + 32'(i << 20);
    e.we    = (i % 5) != 4;
    e.rd    = 5'((i % 31) + 1);
    e.data  = 32'h1000 + 32'(i);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input entry_t p, input logic [1:0] m,
                       input entry_t e0, input entry_t e1);
    exp_valid_i   = pv;
    exp_pc_i      = p.pc;
    exp_instr_i   = p.instr;
    exp_rd_we_i   = p.we;
    exp_rd_i      = p.rd;
    exp_rd_data_i = p.data;
    cmt_valid_i   = m;
    cmt_pc_i      = {e1.pc, e0.pc};
    cmt_instr_i   = {e1.instr, e0.instr};
    cmt_rd_we_i   = {e1.we, e0.we};
    cmt_rd_i      = {e1.rd, e0.rd};
    cmt_rd_data_i = {e1.data, e0.data};
    tick();
    exp_valid_i = 1'b0;
    cmt_valid_i = '0;
  endtask

  task automatic push_e(input entry_t e);
    drive(1'b1, e, 2'b00, e, e);
  endtask

  task automatic commit(input logic [1:0] m, input entry_t e0, input entry_t e1);
    drive(1'b0, e0, m, e0, e1);
  endtask

  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic expect_st(input string tag, input int ready, input int done, input int pass,
                           input int flags, input int instr, input int cyc, input int mis,
                           input int ffpc = -1, input int ffidx = -1);
    status_t s;
    s.tag = tag; s.ready = ready; s.done = done; s.pass = pass; s.flags = flags;
    s.instr = instr; s.cyc = cyc; s.mis = mis; s.ffpc = ffpc; s.ffidx = ffidx;
    sb_q.push_back(s);
  endtask

  task automatic cmp(input string tag, input string fld, input int obs, input int exp);
    if (exp >= 0) begin
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
      end
    end
  endtask

  task automatic check_st();
    status_t s;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      cmp(s.tag, "ready", int'(exp_ready_o), s.ready);
      cmp(s.tag, "done",  int'(done_o), s.done);
      cmp(s.tag, "pass",  int'(pass_o), s.pass);
      cmp(s.tag, "flags", int'({err_mismatch_o, err_underflow_o, err_timeout_o, err_protocol_o}), s.flags);
      cmp(s.tag, "instr", int'(instr_count_o), s.instr);
      cmp(s.tag, "cycle", int'(cycle_count_o), s.cyc);
      cmp(s.tag, "mis",   int'(mismatch_count_o), s.mis);
      cmp(s.tag, "ffpc",  int'(first_fail_pc_o), s.ffpc);
      cmp(s.tag, "ffidx", int'(first_fail_idx_o), s.ffidx);
      $display("%s: ready=%0d done=%0d pass=%0d flags=%b instr=%0d cyc=%0d mis=%0d ffpc=%0h ffidx=%0d",
               s.tag, exp_ready_o, done_o, pass_o,
               {err_mismatch_o, err_underflow_o, err_timeout_o, err_protocol_o},
               instr_count_o, cycle_count_o, mismatch_count_o, first_fail_pc_o, first_fail_idx_o);
    end
  endtask

  initial begin
    entry_t e, c;
    int np, nc;
    rst_i = 1'b0; start_i = 1'b0; end_pc_i = 32'd20;
    exp_valid_i = 1'b0; exp_pc_i = '0; exp_instr_i = '0; exp_rd_we_i = 1'b0;
    exp_rd_i = '0; exp_rd_data_i = '0; cmt_valid_i = '0; cmt_pc_i = '0;
    cmt_instr_i = '0; cmt_rd_we_i = '0; cmt_rd_i = '0; cmt_rd_data_i = '0;

    expect_st("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check_st();
    rst_i = 1'b1;
    tick();

    // Happy path: six matching entries, two commits per cycle, end at PC 20.
    start_run();
    for (int i = 0; i < 6; i++) push_e(mk(i));
    expect_st("happy_c1", 1, 0, 0, 0, 2, 7, 0);
    commit(2'b11, mk(0), mk(1)); check_st();
    expect_st("happy_c2", 1, 0, 0, 0, 4, 8, 0);
    commit(2'b11, mk(2), mk(3)); check_st();
    expect_st("happy_end", 1, 1, 1, 0, 6, 9, 0, 0, 0);
    commit(2'b11, mk(4), mk(5)); check_st();

    // Data mismatch on entry 3 without stopping.
    start_run();
    for (int i = 0; i < 6; i++) begin
      e = mk(i);
      if (i == 3) e.data = 32'h5;
      push_e(e);
    end
    c = mk(3); c.data = 32'h6;
    commit(2'b11, mk(0), mk(1));
    expect_st("mism_c2", 1, 0, 0, 8, 4, 8, 1, 12, 3);
    commit(2'b11, mk(2), c); check_st();
    expect_st("mism_end", 1, 1, 0, 8, 6, 9, 1, 12, 3);
    commit(2'b11, mk(4), mk(5)); check_st();

    // Underflow: one entry buffered, two lanes committed.
    start_run();
    push_e(mk(0));
    expect_st("underflow", 1, 1, 0, 4, 1, 2, 0, 0, 0);
    commit(2'b11, mk(0), mk(1)); check_st();

    // Non-contiguous valid mask.
    start_run();
    push_e(mk(0)); push_e(mk(1));
    expect_st("protocol", 1, 1, 0, 1, 0, 3, 0);
    commit(2'b10, mk(0), mk(1)); check_st();

    // rd=0 ignores data; end on lane 0 leaves lane 1 uncounted.
    end_pc_i = 32'd0;
    e = mk(0); e.rd = 5'd0; e.we = 1'b1; e.data = 32'h11;
    c = e; c.data = 32'h22;
    start_run();
    push_e(e); push_e(mk(1));
    expect_st("rd0_end", 1, 1, 1, 0, 1, 3, 0, 0, 0);
    commit(2'b11, c, mk(1)); check_st();

    // Watchdog with TIMEOUT=8.
    start_run();
    expect_st("tmo_pre", 1, 0, 0, 0, 0, 7, 0);
    repeat (7) tick();
    check_st();
    expect_st("timeout", 1, 1, 0, 2, 0, 8, 0);
    tick(); check_st();

    // Saturation: 20 RUN cycles with COUNT_WIDTH=4.
    end_pc_i = 32'd72;
    start_run();
    for (int i = 0; i < 20; i++) begin
      if (i == 19) expect_st("saturate", 1, 1, 1, 0, 15, 15, 0);
      drive(1'b1, mk(i), (i >= 1) ? 2'b01 : 2'b00, mk((i >= 1) ? i - 1 : 0), mk(0));
    end
    check_st();

    // Fill the FIFO while keeping the watchdog fed, then push+pop when full.
    end_pc_i = 32'hFFFF_FFF0;
    start_run();
    np = 0; nc = 0;
    expect_st("full", 0, 0, 0, 0, 5, 15, 0);
    for (int cyc = 0; cyc < 21; cyc++) begin
      drive(1'b1, mk(np), (cyc % 4 == 3) ? 2'b01 : 2'b00, mk(nc), mk(nc));
      np++;
      if (cyc % 4 == 3) nc++;
    end
    check_st();
    expect_st("push_pop", 1, 0, 0, 0, 6, 15, 0);
    drive(1'b1, mk(np), 2'b01, mk(nc), mk(nc));
    nc++;
    check_st();
    end_pc_i = mk(nc).pc;
    expect_st("full_done", 1, 1, 1, 0, 7, 15, 0);
    commit(2'b01, mk(nc), mk(nc)); check_st();

    // Restart from DONE clears everything and flushes the FIFO.
    expect_st("restart", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    start_run(); check_st();
    expect_st("restart_flush", 1, 1, 0, 4, 0, 1, 0);
    commit(2'b01, mk(0), mk(0)); check_st();

    // Asynchronous reset in the middle of a run.
    start_run();
    push_e(mk(0));
    rst_i = 1'b0;
    #2;
    expect_st("async_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_st();
    rst_i = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_stream_checker.md
Name: commit_stream_checker

Overview:
- Synthesizable commit-stream scoreboard; successor to the single-commit, model-in-bench checking flow.
- Buffers an expected retire trace in a FIFO and compares it against up to N_LANES CPU commits per cycle.
- Detects the end-of-program PC, counts cycles and instructions, flags mismatches, underflow, protocol errors and watchdog timeouts.
- Sits beside cpu on its debug commit ports, in simulation or FPGA self-test.

Parameters:
ADDR_WIDTH, 32, PC width
DATA_WIDTH, 32, register data width
N_LANES, 2, commit lanes per cycle (1..4)
DEPTH, 16, expected-trace FIFO entries (power of 2, >= N_LANES)
COUNT_WIDTH, 32, width of the cycle/instr/mismatch counters
TIMEOUT, 1024, cycles without a commit before failing; 0 disables
STOP_ON_MISMATCH, 0, 1 = go to FAIL on the first mismatch

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
start_i  in  1  start/restart pulse
end_pc_i  in  ADDR_WIDTH  PC of the final instruction
exp_valid_i  in  1  expected entry valid
exp_ready_o  out  1  FIFO can accept
exp_pc_i  in  ADDR_WIDTH  expected PC
exp_instr_i  in  32  expected instruction
exp_rd_we_i  in  1  expected register write
exp_rd_i  in  5  expected destination register
exp_rd_data_i  in  DATA_WIDTH  expected writeback data
cmt_valid_i  in  N_LANES  per-lane commit valid
cmt_pc_i  in  N_LANES*ADDR_WIDTH  committed PCs (lane 0 in the LSBs)
cmt_instr_i  in  N_LANES*32  committed instructions
cmt_rd_we_i  in  N_LANES  committed register writes
cmt_rd_i  in  N_LANES*5  committed rd
cmt_rd_data_i  in  N_LANES*DATA_WIDTH  committed writeback data
done_o  out  1  in DONE or FAIL
pass_o  out  1  DONE with no error flags
err_mismatch_o, err_underflow_o, err_timeout_o, err_protocol_o  out  1 each  sticky error flags
instr_count_o, cycle_count_o, mismatch_count_o  out  COUNT_WIDTH each  statistics
first_fail_pc_o  out  ADDR_WIDTH  PC of the first mismatching commit
first_fail_idx_o  out  COUNT_WIDTH  instruction index of the first mismatch

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE, FIFO empty, all counters/flags/first_fail 0.
  - Outputs in reset: exp_ready_o=1, done_o=0, pass_o=0.
- States:
  - IDLE --start_i--> RUN.
  - RUN --end PC committed--> DONE.
  - RUN --underflow | timeout | protocol | (mismatch && STOP_ON_MISMATCH)--> FAIL.
  - DONE/FAIL --start_i--> RUN.
  - Every entry into RUN clears the counters, flags and first_fail and flushes the FIFO, including a start_i in the same cycle as a push.
- FIFO:
  - exp_ready_o = (occupancy < DEPTH), computed from registered occupancy; pops in the same cycle do not raise it.
  - A push occurs when exp_valid_i && exp_ready_o, in any state except on the restart cycle.
  - A pushed entry is visible for comparison the next cycle.
  - Pointers wrap modulo DEPTH.
- Commits (RUN only; ignored in IDLE/DONE/FAIL):
  - cmt_valid_i must be contiguous from lane 0. If it is not, set err_protocol and go to FAIL; no lanes are compared that cycle.
  - Let k = number of valid lanes. Lanes 0..min(k,occ)-1 are compared against the FIFO head in order and popped.
  - If k > occ: set err_underflow and go to FAIL.
- Compare rule, per lane:
  - pc, instr and rd_we must match.
  - If rd_we=1, rd must also match; rd_data must match unless rd=0.
  - A failing lane increments mismatch_count and sets err_mismatch.
  - On the first mismatch since start, capture first_fail_pc and first_fail_idx (the lane's 0-based instruction index).
  - Multiple mismatching lanes in one cycle: capture the lowest lane.
- End detection:
  - The lowest compared lane with pc == end_pc_i is the final instruction; it is compared and counted.
  - Higher lanes in the same cycle are ignored, neither popped nor counted.
  - Next state is DONE, unless a FAIL condition arose in the same cycle; FAIL has priority.
- Counters:
  - cycle_count increments every cycle in RUN.
  - instr_count increments by the number of compared lanes.
  - All counters saturate at all-ones.
- Watchdog (TIMEOUT>0):
  - The idle counter clears on any cycle with k>0 and increments otherwise.
  - On reaching TIMEOUT: set err_timeout and go to FAIL.
- Output timing:
  - All outputs are registered and reflect a commit cycle on the following cycle.
  - done_o = state in {DONE, FAIL}.
  - pass_o = (state==DONE) && no flags set.
- Reset mid-run: immediate return to IDLE with everything cleared.

Test Plan:
- Happy path, N_LANES=2. Push 6 matching entries at PC 0,4,…,20 (end_pc_i=20); commit 2/cycle -> after 3 commit cycles: done_o=1, pass_o=1, instr_count=6, mismatch_count=0.
- Data mismatch. Entry 3 expects rd_data 0x5 but the CPU commits 0x6 at PC 0xC, STOP_ON_MISMATCH=0 -> err_mismatch=1, mismatch_count=1, first_fail_pc=0xC, first_fail_idx=3; run still ends at DONE with pass_o=0.
- Underflow. FIFO holds 1 entry, CPU commits 2 lanes -> lane 0 compared, err_underflow=1, FAIL, instr_count=1.
- Protocol and rd=0. cmt_valid_i=2'b10 -> err_protocol, FAIL. Separately, rd=0 with differing rd_data -> no mismatch.
- Timeout and saturation. TIMEOUT=8 with no commits -> FAIL, err_timeout=1 and cycle_count=8 seen after the FAIL transition. With COUNT_WIDTH=4, 20 RUN cycles -> cycle_count=15.
- FIFO full, same-cycle push+pop, restart. Fill DEPTH entries -> exp_ready_o=0; commit 1 with push asserted -> push is not taken that cycle. start_i from DONE -> counters 0, FIFO empty, state RUN.
